// File: rtl/rr_lock_arbiter_if.sv
// Bus-arbiter handshake bundle: request/acknowledge in, one-hot and encoded grant out.
// Latency: none (wires only).
// Backpressure: none; requesters hold request until granted.
interface rr_lock_arbiter_if #(
   parameter int PORTS = 4
);
   localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;

   logic [PORTS-1:0] request;
   logic [PORTS-1:0] acknowledge;
   logic [PORTS-1:0] grant;
   logic             grant_valid;
   logic [IW-1:0]    grant_encoded;

   // requester side: drives request/acknowledge, observes the grant
   modport master (
      output request,
      output acknowledge,
      input  grant,
      input  grant_valid,
      input  grant_encoded
   );

   // arbiter side
   modport slave (
      input  request,
      input  acknowledge,
      output grant,
      output grant_valid,
      output grant_encoded
   );
endinterface

// File: rtl/rr_lock_arbiter.sv
// PORTS-way bus arbiter: fixed-priority encoder plus optional round-robin mask, grant locked until owner releases.
// Latency: 1 cycle request-to-grant; grant, grant_valid and grant_encoded are all registered.
// Backpressure: none; losers simply keep requesting, the owner keeps the bus until ack (or request drop).
module rr_lock_arbiter #(
   parameter int PORTS                = 4,
   parameter int ARB_TYPE_ROUND_ROBIN = 1,
   parameter int ARB_BLOCK            = 1,
   parameter int ARB_BLOCK_ACK        = 1,
   parameter int LSB_HIGH_PRIORITY    = 0
) (
   input logic              clk,
   input logic              rst,
   rr_lock_arbiter_if.slave bus
);
   localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OWNED = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [PORTS-1:0] grant_q, grant_d;
   logic [PORTS-1:0] mask_q, mask_d;
   logic [IW-1:0]    owner_q, owner_d;

   logic [PORTS-1:0] req_masked;
   logic [PORTS-1:0] arb_req;
   logic [PORTS-1:0] win_mask;
   logic [IW-1:0]    win_idx;
   logic             win_any;
   logic             release_c;
   int               win_i;

   // Arbitration: masked requests take precedence in round-robin mode, otherwise
   // fall back to the full request vector (wrap-around); then a fixed-priority pick.
   always_comb begin
      req_masked = bus.request & mask_q;
      if ((ARB_TYPE_ROUND_ROBIN != 0) && (req_masked != '0)) begin
         arb_req = req_masked;
      end else begin
         arb_req = bus.request;
      end
      win_any = |arb_req;
      win_i   = 0;
      if (LSB_HIGH_PRIORITY != 0) begin
         for (int i = PORTS - 1; i >= 0; i--) begin
            if (arb_req[i]) win_i = i;
         end
      end else begin
         for (int i = 0; i < PORTS; i++) begin
            if (arb_req[i]) win_i = i;
         end
      end
      win_idx = IW'(win_i);
      // ports strictly below the winner in priority stay eligible next round
      for (int i = 0; i < PORTS; i++) begin
         if (LSB_HIGH_PRIORITY != 0) begin
            win_mask[i] = (i > win_i);
         end else begin
            win_mask[i] = (i < win_i);
         end
      end
   end

   // Release condition for the current owner (ack pulse, or request drop).
   always_comb begin
      if (ARB_BLOCK_ACK != 0) begin
         release_c = bus.acknowledge[owner_q];
      end else begin
         release_c = !bus.request[owner_q];
      end
   end

   // State register: grant, owner index and round-robin mask.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         owner_q <= '0;
         mask_q  <= '1;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         mask_q  <= mask_d;
      end
   end

   // Next state: arbitrate from IDLE, on release, or every cycle when not locking.
   always_comb begin
      logic rearb;
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      mask_d  = mask_q;
      rearb   = 1'b0;
      case (state_q)
         ST_IDLE:  rearb = 1'b1;
         ST_OWNED: rearb = (ARB_BLOCK == 0) || release_c;
         default:  rearb = 1'b1;
      endcase
      if (rearb) begin
         if (win_any) begin
            state_d = ST_OWNED;
            grant_d = '0;
            grant_d[win_idx] = 1'b1;
            owner_d = win_idx;
            if (ARB_TYPE_ROUND_ROBIN != 0) mask_d = win_mask;
         end else begin
            state_d = ST_IDLE;
            grant_d = '0;
            owner_d = '0;
         end
      end
   end

   // Outputs straight from registers.
   always_comb begin
      bus.grant         = grant_q;
      bus.grant_valid   = (state_q == ST_OWNED);
      bus.grant_encoded = owner_q;
   end
endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Self-checking bench: two arbiters (ack release / request-drop release) against a rotating-search model.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: n/a; stimulus is directed scenarios followed by random request/ack traffic.
module tb_rr_lock_arbiter;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;
   int   own0, last0, own1, last1;

   rr_lock_arbiter_if #(.PORTS(4)) if0 ();
   rr_lock_arbiter_if #(.PORTS(4)) if1 ();

   rr_lock_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1),
                     .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIORITY(0))
      dut_ack (.clk(clk), .rst(rst), .bus(if0));

   rr_lock_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1),
                     .ARB_BLOCK_ACK(0), .LSB_HIGH_PRIORITY(0))
      dut_req (.clk(clk), .rst(rst), .bus(if1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Model: owner < 0 means idle. Round-robin = search downward starting just
   // below the last winner, wrapping; last=0 after reset makes that a plain
   // highest-index-first search.
   task automatic model_step(input bit ackmode, input logic [3:0] r, input logic [3:0] a,
                             inout int own, inout int last);
      bit rel;
      if (own < 0)      rel = 1'b1;
      else if (ackmode) rel = a[own];
      else              rel = !r[own];
      if (rel) begin
         if (r == 4'b0000) begin
            own = -1;
         end else begin
            for (int d = 1; d <= 4; d++) begin
               int p;
               p = (last - d + 8) % 4;
               if (r[p]) begin
                  own = p;
                  break;
               end
            end
            last = own;
         end
      end
   endtask

   function automatic logic [31:0] exp_grant(input int own);
      return (own < 0) ? 32'd0 : (32'd1 << own);
   endfunction

   task automatic compare_all();
      check("ack_grant", 32'(if0.grant), exp_grant(own0));
      check("ack_valid", 32'(if0.grant_valid), (own0 >= 0) ? 32'd1 : 32'd0);
      check("ack_enc",   32'(if0.grant_encoded), (own0 >= 0) ? 32'(own0) : 32'd0);
      check("req_grant", 32'(if1.grant), exp_grant(own1));
      check("req_valid", 32'(if1.grant_valid), (own1 >= 0) ? 32'd1 : 32'd0);
      check("req_enc",   32'(if1.grant_encoded), (own1 >= 0) ? 32'(own1) : 32'd0);
   endtask

   task automatic step(input logic [3:0] r, input logic [3:0] a);
      @(negedge clk);
      if0.request = r; if0.acknowledge = a;
      if1.request = r; if1.acknowledge = a;
      model_step(1'b1, r, a, own0, last0);
      model_step(1'b0, r, a, own1, last1);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   // Reset asserted between edges; outputs must clear before the next edge.
   task automatic async_reset(input string tag);
      @(negedge clk);
      #2;
      rst = 1'b1;
      if0.request = '0; if0.acknowledge = '0;
      if1.request = '0; if1.acknowledge = '0;
      #1;
      check({tag, "_grant0"}, 32'(if0.grant), 32'd0);
      check({tag, "_valid0"}, 32'(if0.grant_valid), 32'd0);
      check({tag, "_enc0"},   32'(if0.grant_encoded), 32'd0);
      check({tag, "_grant1"}, 32'(if1.grant), 32'd0);
      own0 = -1; last0 = 0; own1 = -1; last1 = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] r, a;
      n_cmp = 0; n_bad = 0;
      own0 = -1; last0 = 0; own1 = -1; last1 = 0;
      rst = 1'b1;
      if0.request = '0; if0.acknowledge = '0;
      if1.request = '0; if1.acknowledge = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_grant", 32'(if0.grant), 32'd0);
      check("rst_valid", 32'(if0.grant_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // idle after reset
      for (int i = 0; i < 5; i++) step(4'b0000, 4'b0000);

      // single requester, then ack release
      step(4'b0001, 4'b0000);
      check("single_grant", 32'(if0.grant), 32'h1);
      check("single_enc",   32'(if0.grant_encoded), 32'd0);
      step(4'b0000, 4'b0001);
      check("single_rel", 32'(if0.grant), 32'h0);

      // fairness rotation with everyone requesting
      step(4'b1111, 4'b0000);
      check("rr_0", 32'(if0.grant_encoded), 32'd3);
      step(4'b1111, 4'b1000);
      check("rr_1", 32'(if0.grant_encoded), 32'd2);
      step(4'b1111, 4'b0100);
      check("rr_2", 32'(if0.grant_encoded), 32'd1);
      step(4'b1111, 4'b0010);
      check("rr_3", 32'(if0.grant_encoded), 32'd0);
      step(4'b1111, 4'b0001);
      check("rr_4", 32'(if0.grant), 32'h8);
      step(4'b0000, 4'b1000);

      // lock: no ack holds, non-owner ack ignored, owner ack moves on
      for (int i = 0; i < 6; i++) begin
         step(4'b0110, 4'b0000);
         check("lock_hold", 32'(if0.grant), 32'h4);
      end
      step(4'b0110, 4'b0010);
      check("lock_nonowner", 32'(if0.grant), 32'h4);
      step(4'b0110, 4'b0100);
      check("lock_switch", 32'(if0.grant), 32'h2);
      step(4'b0000, 4'b0010);

      // request-release mode on the second arbiter, fresh mask
      async_reset("rst_a");
      step(4'b1010, 4'b0000);
      check("rq_first", 32'(if1.grant), 32'h8);
      step(4'b0010, 4'b0000);
      check("rq_drop3", 32'(if1.grant), 32'h2);
      check("ackmode_keeps", 32'(if0.grant), 32'h8);
      step(4'b0000, 4'b0000);
      check("rq_idle", 32'(if1.grant_valid), 32'd0);
      step(4'b0000, 4'b1000);

      // reset in the middle of a grant
      step(4'b0010, 4'b0000);
      check("pre_rst", 32'(if0.grant), 32'h2);
      async_reset("rst_b");
      step(4'b1010, 4'b0000);
      check("post_rst_b", 32'(if0.grant), 32'h8);
      // reset while port 3 owns: a stale mask would pick port 1 here
      async_reset("rst_c");
      step(4'b1010, 4'b0000);
      check("post_rst_c", 32'(if0.grant), 32'h8);
      check("post_rst_c1", 32'(if1.grant), 32'h8);

      // sole requester re-granted with grant_valid held
      step(4'b1000, 4'b1000);
      check("sole_regrant", 32'(if0.grant), 32'h8);

      // random traffic
      r = 4'b0000;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) < 3) r = 4'($urandom_range(0, 15));
         a = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         if (own0 >= 0 && $urandom_range(0, 2) == 0) a[own0] = 1'b1;
         step(r, a);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- Parameterised N-way arbiter that shares one bus resource among PORTS requesters.
- Selects a winner with a fixed-priority encoder; in round-robin mode, a second masked encoder provides fairness.
- Holds (locks) the grant until the owner releases it, so a multi-cycle bus transaction is never interrupted.
- Sits in front of the shared bus mux in the CPU bus fabric; drives its select lines from grant_encoded.

Parameters:
- PORTS, 4: number of requesters; must be 2 or more.
- ARB_TYPE_ROUND_ROBIN, 1: 1 = round-robin; 0 = fixed priority.
- ARB_BLOCK, 1: 1 = hold the grant until released; 0 = re-arbitrate every cycle.
- ARB_BLOCK_ACK, 1: only used when ARB_BLOCK=1. 1 = release on an acknowledge pulse; 0 = release when the owner drops its request.
- LSB_HIGH_PRIORITY, 0: 0 = highest index has highest fixed priority; 1 = index 0 has highest fixed priority.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- request  input  PORTS  request[i]=1 means port i wants the bus; level signal.
- acknowledge  input  PORTS  acknowledge[i] pulse means port i is done; honoured only for the current owner.
- grant  output  PORTS  one-hot grant, registered; all-zero when no owner.
- grant_valid  output  1  1 when grant is non-zero, registered.
- grant_encoded  output  $clog2(PORTS)  binary index of the owner; 0 when grant_valid=0.

Behaviour:
- Reset (asserted at any time, including mid-grant): grant=0, grant_valid=0, grant_encoded=0 immediately (asynchronous). Round-robin mask is cleared to all ones, i.e. pure fixed priority on the first arbitration after reset.
- All outputs are registered. A request seen at edge N produces its grant after edge N, giving 1-cycle latency from request to grant.
- The block has two states, IDLE (grant_valid=0) and OWNED (grant_valid=1).
- IDLE transitions:
  - request==0: stay in IDLE.
  - Otherwise: arbitrate, load grant, go to OWNED.
- OWNED with ARB_BLOCK=1: keep the grant while the release condition is false. Release condition:
  - ARB_BLOCK_ACK=1: acknowledge[owner]=1.
  - ARB_BLOCK_ACK=0: request[owner]=0.
- OWNED, release cycle:
  - Arbitrate among the current requests with the updated mask.
  - If any request wins, the grant switches to that port directly (no idle bubble).
  - If no requests remain, go to IDLE.
- OWNED with ARB_BLOCK=0: re-arbitrate every cycle; acknowledge is ignored.
- Fixed-priority selection:
  - LSB_HIGH_PRIORITY=0: the highest set index wins.
  - LSB_HIGH_PRIORITY=1: the lowest set index wins.
- Round-robin selection, after a grant to port k:
  - The mask keeps only ports of lower priority than k. With LSB_HIGH_PRIORITY=0 that is indices < k; with LSB_HIGH_PRIORITY=1 it is indices > k.
  - If request & mask is non-zero, the winner is the fixed-priority winner of request & mask.
  - Otherwise the winner is the fixed-priority winner of the unmasked request. This gives wrap-around.
  - The mask updates only when a new grant is loaded.
- ARB_TYPE_ROUND_ROBIN=0: the mask is never applied.
- Acknowledge on a non-owner port, or in IDLE, is ignored.
- Owner requesting again at release (ack mode): the owner is treated as lowest priority, so any other requester wins first. A sole requester is re-granted in the next cycle with grant_valid staying 1.
- An owner dropping its request in ack mode does not release the grant; only the ack does.
- Invariants: grant is always one-hot or zero; grant_encoded matches grant; grant_valid equals |grant.

Test Plan:
All scenarios use PORTS=4, LSB_HIGH_PRIORITY=0, ARB_TYPE_ROUND_ROBIN=1, ARB_BLOCK=1, ARB_BLOCK_ACK=1 unless stated.
1. Reset and idle: assert rst, then release it with request=0000 for 5 cycles -> grant=0000, grant_valid=0, grant_encoded=0 throughout.
2. Single requester: request=0001 -> one cycle later grant=0001, grant_valid=1, grant_encoded=0. Then pulse acknowledge=0001 with request=0000 -> next cycle grant=0000.
3. Fairness: hold request=1111 and pulse ack on the owner each grant -> grant sequence 1000, 0100, 0010, 0001, 1000 (encoded 3, 2, 1, 0, 3).
4. Lock: request=0110 with no ack for 6 cycles -> grant stays 0100. Pulse acknowledge=0010 (non-owner) -> no change. Pulse acknowledge=0100 -> next cycle grant=0010.
5. Request-release mode (ARB_BLOCK_ACK=0): request=1010 -> grant=1000. Drop request[3] -> next cycle grant=0010. Drop request[1] -> grant=0000, grant_valid=0.
6. Reset mid-grant: while grant=0010, assert rst asynchronously between edges -> outputs 0 before the next edge. After release, with request=1010 -> grant=1000 (mask cleared).
